// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative multiply/divide unit with architectural HI/LO.
// MULT/MULTU use one shift-add step per cycle; DIV/DIVU use one restoring
// shift-subtract step per cycle. Signed operations run on magnitudes and
// fix the signs on the last step.
// Optional macro MULDIV_EARLY_DONE_EN: a zero data_2 skips the iterations
// and finishes one cycle after issue.
module mul_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] data_1,
   input  logic [WIDTH-1:0] data_2,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int               CNT_W    = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST     = CNT_W'(WIDTH - 1);
   localparam logic [2:0]       OP_MULT  = 3'd0;
   localparam logic [2:0]       OP_MULTU = 3'd1;
   localparam logic [2:0]       OP_DIV   = 3'd2;
   localparam logic [2:0]       OP_MTHI  = 3'd4;
   localparam logic [2:0]       OP_MTLO  = 3'd5;

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FINISH = 2'd2} state_t;

   state_t            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              busy_q, done_q;
   logic [WIDTH-1:0]  hi_q, lo_q;

   // In-flight operation: kind, result signs, divide-by-zero flag, raw dividend
   logic              mul_q, neg_q, rneg_q, dz_q;
   logic [WIDTH-1:0]  opb_q, acc_q, wrk_q, a_raw_q;

   logic              issue, is_mul, is_sgn, sa, sb;
   logic [WIDTH:0]    add_sum, shifted, trial;
   logic [WIDTH-1:0]  step_acc_d, step_wrk_d, res_hi_d, res_lo_d;
   logic [2*WIDTH-1:0] prod_d;

   function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                  input logic n);
      return n ? (~v + 1'b1) : v;
   endfunction

   assign is_mul = (op == OP_MULT) || (op == OP_MULTU);
   assign is_sgn = (op == OP_MULT) || (op == OP_DIV);
   assign sa     = is_sgn & data_1[WIDTH-1];
   assign sb     = is_sgn & data_2[WIDTH-1];
   assign issue  = (state_q == IDLE) && start && !op[2];

   // One iteration step; on the last step also the sign-corrected result
   always_comb begin
      add_sum = {1'b0, acc_q} + (wrk_q[0] ? {1'b0, opb_q} : '0);
      shifted = {acc_q, wrk_q[WIDTH-1]};
      trial   = shifted - {1'b0, opb_q};
      if (mul_q) begin
         step_acc_d = add_sum[WIDTH:1];
         step_wrk_d = {add_sum[0], wrk_q[WIDTH-1:1]};
      end else if (!trial[WIDTH]) begin
         step_acc_d = trial[WIDTH-1:0];
         step_wrk_d = {wrk_q[WIDTH-2:0], 1'b1};
      end else begin
         step_acc_d = shifted[WIDTH-1:0];
         step_wrk_d = {wrk_q[WIDTH-2:0], 1'b0};
      end
      prod_d = {step_acc_d, step_wrk_d};
      if (neg_q) prod_d = ~prod_d + 1'b1;
      if (mul_q) begin
         res_hi_d = prod_d[2*WIDTH-1:WIDTH];
         res_lo_d = prod_d[WIDTH-1:0];
      end else if (dz_q) begin
         res_hi_d = a_raw_q;
         res_lo_d = '1;
      end else begin
         res_hi_d = cond_neg(step_acc_d, rneg_q);
         res_lo_d = cond_neg(step_wrk_d, neg_q);
      end
   end

   // Datapath: latch magnitudes on issue, advance one step per RUN cycle
   always_ff @(posedge clk) begin
      if (issue) begin
         mul_q   <= is_mul;
         neg_q   <= sa ^ sb;
         rneg_q  <= sa;
         dz_q    <= (data_2 == '0);
         a_raw_q <= data_1;
         acc_q   <= '0;
         wrk_q   <= is_mul ? cond_neg(data_2, sb) : cond_neg(data_1, sa);
         opb_q   <= is_mul ? cond_neg(data_1, sa) : cond_neg(data_2, sb);
      end else if (state_q == RUN) begin
         acc_q   <= step_acc_d;
         wrk_q   <= step_wrk_d;
      end
   end

   // Control FSM with registered busy/done and the architectural HI/LO
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (issue) begin
`ifdef MULDIV_EARLY_DONE_EN
                  if (data_2 == '0) begin
                     state_q <= FINISH;
                     done_q  <= 1'b1;
                     hi_q    <= is_mul ? '0 : data_1;
                     lo_q    <= is_mul ? '0 : '1;
                  end else
`endif
                  begin
                     state_q <= RUN;
                     busy_q  <= 1'b1;
                     cnt_q   <= '0;
                  end
               end else if (start && (op == OP_MTHI)) begin
                  hi_q <= data_1;
               end else if (start && (op == OP_MTLO)) begin
                  lo_q <= data_1;
               end
            end
            RUN: begin
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == LAST) begin
                  state_q <= FINISH;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  hi_q    <= res_hi_d;
                  lo_q    <= res_lo_d;
               end
            end
            FINISH: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule
